// File: rtl/gecko_reg_scoreboard_pkg.sv
// gecko_reg_scoreboard_pkg: shared register-status type and encodings for the scoreboard.
package gecko_reg_scoreboard_pkg;
   localparam int COUNTER_WIDTH = 2;
   typedef logic [COUNTER_WIDTH-1:0] gecko_reg_status_t;
   localparam gecko_reg_status_t GECKO_REG_STATUS_VALID = '0;
   localparam gecko_reg_status_t GECKO_REG_STATUS_FULL = '1;
endpackage

// File: rtl/gecko_reg_scoreboard_if.sv
// gecko_reg_scoreboard_if: decode query, issue and retire signals of the register scoreboard.
interface gecko_reg_scoreboard_if;
   import gecko_reg_scoreboard_pkg::*;
   logic [4:0] rs1_addr, rs2_addr, rd_addr;
   gecko_reg_status_t rs1_status, rs2_status, rd_status;
   logic issue_valid, issue_ready, issue_fwd;
   logic [4:0] issue_rd;
   logic retire0_valid, retire1_valid;
   logic [4:0] retire0_rd, retire1_rd;
   logic [4:0] exec_saved;
   logic error;
   modport master(
      output rs1_addr, rs2_addr, rd_addr, issue_valid, issue_rd, issue_fwd,
             retire0_valid, retire0_rd, retire1_valid, retire1_rd,
      input  rs1_status, rs2_status, rd_status, issue_ready, exec_saved, error
   );
   modport slave(
      input  rs1_addr, rs2_addr, rd_addr, issue_valid, issue_rd, issue_fwd,
             retire0_valid, retire0_rd, retire1_valid, retire1_rd,
      output rs1_status, rs2_status, rd_status, issue_ready, exec_saved, error
   );
endinterface

// File: rtl/gecko_reg_scoreboard_counter.sv
// gecko_reg_scoreboard_counter: saturating up/2-down outstanding-write counter with underflow flag.
module gecko_reg_scoreboard_counter
   import gecko_reg_scoreboard_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_i,
   input  logic              dec0_i,
   input  logic              dec1_i,
   output gecko_reg_status_t count_o,
   output logic              underflow_o
);
   gecko_reg_status_t count_q, count_d;
   logic [COUNTER_WIDTH:0] up, down;
   always_comb begin
      up = {1'b0, count_q} + (COUNTER_WIDTH+1)'(inc_i);
      down = (COUNTER_WIDTH+1)'(dec0_i) + (COUNTER_WIDTH+1)'(dec1_i);
      underflow_o = down > up;
      count_d = underflow_o ? GECKO_REG_STATUS_VALID : COUNTER_WIDTH'(up - down);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) count_q <= GECKO_REG_STATUS_VALID;
      else count_q <= count_d;
   assign count_o = count_q;
endmodule

// File: rtl/gecko_reg_scoreboard.sv
// gecko_reg_scoreboard: per-register outstanding-write tracking, issue gating and forward tracking.
module gecko_reg_scoreboard
   import gecko_reg_scoreboard_pkg::*;
(
   input logic clk,
   input logic rst,
   gecko_reg_scoreboard_if.slave sb
);
   gecko_reg_status_t cnt [32];
   logic [31:1] inc, dec0, dec1, uflow;
   logic issue_fire;
   logic [4:0] exec_q, exec_d;
   logic error_q, error_d;
   assign cnt[0] = GECKO_REG_STATUS_VALID;
   assign sb.issue_ready = (cnt[sb.issue_rd] != GECKO_REG_STATUS_FULL) || sb.issue_rd == 5'd0;
   assign issue_fire = sb.issue_valid && sb.issue_ready && sb.issue_rd != 5'd0;
   genvar r;
   generate
      for (r = 1; r < 32; r++) begin : g_reg
         assign inc[r] = issue_fire && sb.issue_rd == 5'(r);
         assign dec0[r] = sb.retire0_valid && sb.retire0_rd == 5'(r);
         assign dec1[r] = sb.retire1_valid && sb.retire1_rd == 5'(r);
         gecko_reg_scoreboard_counter u_cnt (
            .clk(clk), .rst(rst), .inc_i(inc[r]), .dec0_i(dec0[r]), .dec1_i(dec1[r]),
            .count_o(cnt[r]), .underflow_o(uflow[r])
         );
      end
   endgenerate
   assign sb.rs1_status = cnt[sb.rs1_addr];
   assign sb.rs2_status = cnt[sb.rs2_addr];
   assign sb.rd_status = cnt[sb.rd_addr];
   // a non-forwardable write to the saved register supersedes the forwarded value
   always_comb begin
      exec_d = !issue_fire ? exec_q : sb.issue_fwd ? sb.issue_rd : sb.issue_rd == exec_q ? 5'd0 : exec_q;
      error_d = error_q | (|uflow);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         exec_q <= 5'd0;
         error_q <= 1'b0;
      end else begin
         exec_q <= exec_d;
         error_q <= error_d;
      end
   assign sb.exec_saved = exec_q;
   assign sb.error = error_q;
endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// tb_gecko_reg_scoreboard: directed stimulus with queued expectations checked by a negedge monitor.
module tb_gecko_reg_scoreboard;
   typedef struct {
      string name;
      int    sel;
      int    exp;
   } chk_t;
   localparam int S_RS1 = 0, S_RS2 = 1, S_RD = 2, S_RDY = 3, S_EXEC = 4, S_ERR = 5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   chk_t q[$];
   gecko_reg_scoreboard_if sb();
   gecko_reg_scoreboard dut(.clk(clk), .rst(rst), .sb(sb));
   always #5 clk = ~clk;
   function automatic int actual(int s);
      case (s)
         S_RS1:   return int'(sb.rs1_status);
         S_RS2:   return int'(sb.rs2_status);
         S_RD:    return int'(sb.rd_status);
         S_RDY:   return int'(sb.issue_ready);
         S_EXEC:  return int'(sb.exec_saved);
         default: return int'(sb.error);
      endcase
   endfunction
   initial forever begin
      @(negedge clk);
      while (q.size() > 0) begin
         chk_t c;
         int a;
         c = q.pop_front();
         a = actual(c.sel);
         checks++;
         if (a != c.exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", c.name, a, c.exp);
         end
      end
   end
   task automatic cyc(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(string n, int s, int e);
      q.push_back('{n, s, e});
   endtask
   task automatic drain();
      for (int i = 0; i < 4 && q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL monitor_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask
   task automatic idle();
      sb.issue_valid = 0; sb.issue_fwd = 0; sb.issue_rd = 0;
      sb.retire0_valid = 0; sb.retire0_rd = 0; sb.retire1_valid = 0; sb.retire1_rd = 0;
   endtask
   task automatic issue(logic [4:0] r, logic f);
      sb.issue_valid = 1; sb.issue_rd = r; sb.issue_fwd = f;
   endtask
   initial begin
      idle();
      sb.rs1_addr = 5; sb.rs2_addr = 3; sb.rd_addr = 5;
      cyc(2);
      rst = 0;
      chk("reset_rs1_x5", S_RS1, 0); chk("reset_exec", S_EXEC, 0);
      chk("reset_err", S_ERR, 0); chk("reset_ready", S_RDY, 1);
      drain();
      issue(5, 0);
      cyc(3);
      chk("x5_full", S_RD, 3); chk("x5_full_not_ready", S_RDY, 0);
      drain();
      cyc();
      chk("x5_blocked_stays_3", S_RD, 3);
      drain();
      idle(); sb.retire0_valid = 1; sb.retire0_rd = 5; sb.issue_rd = 5;
      cyc();
      idle(); sb.issue_rd = 5;
      chk("x5_after_retire", S_RD, 2); chk("x5_ready_again", S_RDY, 1);
      drain();
      issue(3, 1); cyc(); idle();
      chk("exec_fwd_x3", S_EXEC, 3);
      drain();
      issue(3, 0); cyc(); idle();
      chk("exec_superseded", S_EXEC, 0);
      drain();
      issue(3, 1); cyc(); issue(4, 0); cyc(); idle();
      chk("exec_unchanged_x4", S_EXEC, 3); chk("x3_count_full", S_RS2, 3);
      drain();
      issue(3, 0); cyc(); idle();
      chk("exec_blocked_issue", S_EXEC, 3); chk("x3_blocked_count", S_RS2, 3);
      drain();
      sb.retire1_valid = 1; sb.retire1_rd = 9; sb.rs1_addr = 9;
      cyc(); idle();
      chk("x9_underflow_sat", S_RS1, 0); chk("underflow_err", S_ERR, 1);
      drain();
      cyc(2);
      chk("err_sticky", S_ERR, 1);
      drain();
      sb.rs1_addr = 5;
      rst = 1;
      cyc();
      rst = 0;
      chk("midrst_x5", S_RS1, 0); chk("midrst_x3", S_RS2, 0);
      chk("midrst_exec", S_EXEC, 0); chk("midrst_err", S_ERR, 0);
      drain();
      sb.rd_addr = 7; sb.rs2_addr = 7;
      issue(7, 0); cyc(2);
      sb.retire0_valid = 1; sb.retire0_rd = 7; sb.retire1_valid = 1; sb.retire1_rd = 7;
      cyc(); idle();
      chk("x7_net", S_RD, 1); chk("x7_net_err", S_ERR, 0);
      drain();
      issue(0, 0); sb.retire0_valid = 1; sb.retire0_rd = 0; sb.retire1_valid = 1; sb.retire1_rd = 0;
      sb.rs1_addr = 0;
      chk("x0_ready", S_RDY, 1);
      drain();
      cyc(); idle();
      chk("x0_status", S_RS1, 0); chk("x0_no_err", S_ERR, 0); chk("x7_untouched", S_RS2, 1);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
